// File: rtl/fifo_pkt_reader.sv
//==============================================================================
// Module      : fifo_pkt_reader
// Description : Drains a byte FIFO (non-show-ahead) into a UDP transmit stack
//               as fixed-length packets. A packet is requested once PKT_LEN
//               bytes are available; after the grant the bytes are streamed
//               through a 2-entry skid buffer with valid/ready handshaking.
//               Optional idle-flush: define PKT_TIMEOUT_EN to send a short
//               packet holding whatever is buffered after TIMEOUT_CYC cycles.
// Ports       : clk, srst (async, active-high)
//               fifo_re / fifo_dout / fifo_valid / fifo_empty / fifo_rdusedw
//                 - read side of the byte FIFO
//               tx_req / tx_len / tx_ack  - packet request/grant handshake
//               tx_data / tx_data_valid / tx_data_ready - payload stream
//               pkt_done - one-cycle pulse after the last byte transfers
//               busy     - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_pkt_reader #(
  parameter int PKT_LEN     = 1024,
  parameter int USEDW_WIDTH = 12,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   srst,
  output logic                   fifo_re,
  input  logic [7:0]             fifo_dout,
  input  logic                   fifo_valid,
  input  logic                   fifo_empty,
  input  logic [USEDW_WIDTH-1:0] fifo_rdusedw,
  output logic                   tx_req,
  output logic [15:0]            tx_len,
  input  logic                   tx_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_data_valid,
  input  logic                   tx_data_ready,
  output logic                   pkt_done,
  output logic                   busy
);

  localparam logic [USEDW_WIDTH-1:0] PKT_LEN_U  = USEDW_WIDTH'(PKT_LEN);
  localparam logic [15:0]            PKT_LEN_16 = 16'(PKT_LEN);

  if (PKT_LEN < 1 || PKT_LEN > 2047 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fifo_pkt_reader: PKT_LEN must be 1..2047 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tx_len_q, tx_len_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;     // reads still to issue
  logic [15:0] xfer_cnt_q, xfer_cnt_d; // transfers still to complete
  logic [7:0]  skid_q [2];
  logic        skid_wr_q, skid_rd_q;
  logic [1:0]  skid_cnt_q, skid_cnt_d;
  logic [1:0]  outst_q, outst_d;       // reads issued whose data has not arrived

  logic push, pop, xfer, room, read_ok, timer_hit;

  // Data returning for a read we never issued is dropped.
  assign push          = fifo_valid && (outst_q != 2'd0);
  assign tx_data_valid = (skid_cnt_q != 2'd0);
  assign pop           = tx_data_valid && tx_data_ready;
  assign xfer          = pop && (state_q == STREAM);
  // The entry leaving this cycle frees its slot, which is what allows a
  // read every cycle while the sink keeps up.
  assign room          = ({1'b0, skid_cnt_q} - {2'b00, pop} + {1'b0, outst_q}) < 3'd2;
  assign read_ok       = !fifo_empty && room;

  assign tx_data = skid_q[skid_rd_q];
  assign tx_len  = tx_len_q;
  assign busy    = (state_q != IDLE);

`ifdef PKT_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_32 = 32'(TIMEOUT_CYC);
  logic [31:0] timer_q, timer_d;
  logic        timer_run;

  // A zero fill count is excluded so a flush never requests an empty packet.
  assign timer_run = (state_q == IDLE) && !fifo_empty &&
                     (fifo_rdusedw < PKT_LEN_U) && (fifo_rdusedw != '0);
  assign timer_hit = timer_run && (timer_q >= TIMEOUT_32 - 32'd1);

  always_comb begin
    timer_d = 32'd0;
    if (timer_run && !timer_hit) begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_len_d   = tx_len_q;
    rd_cnt_d   = rd_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    fifo_re    = 1'b0;
    tx_req     = 1'b0;
    pkt_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rdusedw >= PKT_LEN_U) begin
          state_d  = REQ;
          tx_len_d = PKT_LEN_16;
        end else if (timer_hit) begin
          state_d  = REQ;
          tx_len_d = 16'(fifo_rdusedw);
        end
      end
      REQ: begin
        tx_req = !tx_ack;
        if (tx_ack) begin
          // First read is issued in the grant cycle so data reaches the
          // sink two cycles after tx_ack.
          fifo_re    = read_ok && (tx_len_q != 16'd0);
          state_d    = STREAM;
          rd_cnt_d   = tx_len_q - {15'd0, read_ok && (tx_len_q != 16'd0)};
          xfer_cnt_d = tx_len_q;
        end
      end
      STREAM: begin
        fifo_re = read_ok && (rd_cnt_q != 16'd0);
        if (read_ok && (rd_cnt_q != 16'd0)) begin
          rd_cnt_d = rd_cnt_q - 16'd1;
        end
        if (xfer && (xfer_cnt_q != 16'd0)) begin
          xfer_cnt_d = xfer_cnt_q - 16'd1;
          if (xfer_cnt_q == 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        pkt_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, pop};
  assign outst_d    = outst_q + {1'b0, fifo_re} - {1'b0, push};

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q    <= IDLE;
      tx_len_q   <= 16'h0000;
      rd_cnt_q   <= 16'd0;
      xfer_cnt_q <= 16'd0;
      skid_q[0]  <= 8'h00;
      skid_q[1]  <= 8'h00;
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      outst_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      tx_len_q   <= tx_len_d;
      rd_cnt_q   <= rd_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      skid_cnt_q <= skid_cnt_d;
      outst_q    <= outst_d;
      if (push) begin
        skid_q[skid_wr_q] <= fifo_dout;
        skid_wr_q         <= ~skid_wr_q;
      end
      if (pop) begin
        skid_rd_q <= ~skid_rd_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_pkt_reader;

  localparam int PKT_LEN     = 16;
  localparam int USEDW_WIDTH = 12;
  localparam int TIMEOUT_CYC = 100;

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   fifo_re;
  logic [7:0]             fifo_dout = 8'h00;
  logic                   fifo_valid = 1'b0;
  logic                   fifo_empty;
  logic [USEDW_WIDTH-1:0] fifo_rdusedw;
  logic                   tx_req;
  logic [15:0]            tx_len;
  logic                   tx_ack;
  logic [7:0]             tx_data;
  logic                   tx_data_valid;
  logic                   tx_data_ready;
  logic                   pkt_done;
  logic                   busy;

  always #5 clk = ~clk;

  fifo_pkt_reader #(
    .PKT_LEN(PKT_LEN), .USEDW_WIDTH(USEDW_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .srst(srst),
    .fifo_re(fifo_re), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_empty(fifo_empty), .fifo_rdusedw(fifo_rdusedw),
    .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .pkt_done(pkt_done), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- byte FIFO model (non-show-ahead) ----------------
  logic [7:0] fmem [0:4095];
  int wptr = 0, rptr = 0;
  int flush_gen = 0, flush_seen = 0;
  int gap_ptr = -1, gap_len_cfg = 0, gap_last = -2, gap_left = 0;

  assign fifo_empty   = (wptr == rptr) || (gap_left != 0);
  assign fifo_rdusedw = USEDW_WIDTH'(wptr - rptr);

  always @(posedge clk) begin
    fifo_valid <= 1'b0;
    if (flush_seen != flush_gen) begin
      rptr       <= wptr;
      flush_seen <= flush_gen;
    end else if (fifo_re && !fifo_empty) begin
      fifo_dout  <= fmem[rptr % 4096];
      rptr       <= rptr + 1;
      fifo_valid <= 1'b1;
    end
    if (gap_left != 0) gap_left <= gap_left - 1;
    else if (gap_len_cfg != 0 && rptr == gap_ptr && gap_last != gap_ptr) begin
      gap_left <= gap_len_cfg;
      gap_last <= gap_ptr;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stack responder ----------------
  int ack_dly  = 3;
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  initial begin : responder
    int req_seen;
    bit tog;
    req_seen = 0; tog = 1'b0;
    tx_ack = 1'b0; tx_data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ack = 1'b0;
      if (tx_req) begin
        req_seen++;
        if (req_seen == ack_dly) tx_ack = 1'b1;
      end else req_seen = 0;
      tog = ~tog;
      case (rdy_mode)
        0:       tx_data_ready = 1'b1;
        1:       tx_data_ready = tog;
        default: tx_data_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  int n_reads = 0, n_under = 0, n_done = 0, n_req_rise = 0, req_rise_cyc = 0;
  int ack_cyc = 0, rx_cnt = 0, stall_err = 0, idle_valid = 0;
  logic [15:0] len_at_ack = 16'h0;
  logic [7:0]  rx_mem [0:4095];
  int          rx_cyc [0:4095];
  initial begin : monitor
    bit prev_stall, prev_req;
    logic [7:0] prev_data;
    prev_stall = 1'b0; prev_req = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!srst) begin
        if (fifo_re) begin
          if (fifo_empty) n_under++;
          else n_reads++;
        end
        if (prev_stall && !(tx_data_valid && tx_data == prev_data)) stall_err++;
        prev_stall = tx_data_valid && !tx_data_ready;
        prev_data  = tx_data;
        if (tx_data_valid && tx_data_ready) begin
          rx_mem[rx_cnt % 4096] = tx_data;
          rx_cyc[rx_cnt % 4096] = cyc;
          rx_cnt++;
        end
        if (pkt_done) n_done++;
        if (tx_req && !prev_req) begin n_req_rise++; req_rise_cyc = cyc; end
        if (tx_ack) begin ack_cyc = cyc; len_at_ack = tx_len; end
        if (busy && !tx_data_valid) idle_valid++;
        prev_req = tx_req;
      end else begin
        prev_stall = 1'b0;
        prev_req   = 1'b0;
      end
    end
  end

  // ---------------- reference data and helpers ----------------
  logic [7:0] exp_mem [0:4095];
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic write_bytes(input int n, input int rnd);
    logic [7:0] b;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      b = rnd != 0 ? 8'($urandom) : 8'(k);
      fmem[wptr % 4096]       = b;
      exp_mem[exp_cnt % 4096] = b;
      exp_cnt++;
      wptr++;
    end
  endtask

  task automatic check_data(input string name, input int b_rx, input int b_exp, input int n);
    int errs;
    errs = 0;
    for (int k = 0; k < n; k++)
      if (rx_mem[(b_rx + k) % 4096] !== exp_mem[(b_exp + k) % 4096]) errs++;
    chk(name, 64'(errs), 64'd0);
  endtask

  task automatic wait_done(input string name, input int b_done, input int pkts);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (n_done - b_done >= pkts && !busy) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  typedef struct {
    int nbytes;
    int rdy_mode;
    int ack_dly;    // -1: random 1..6
    int gap;        // forced-empty cycles after 8 reads, 0: none
    int rnd;        // random payload bytes
    int exp_pkts;
    int exp_reads;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int b_reads, b_under, b_done, b_rx, b_exp, b_stall, b_idle;
    b_reads = n_reads; b_under = n_under; b_done = n_done; b_rx = rx_cnt;
    b_exp = exp_cnt; b_stall = stall_err; b_idle = idle_valid;
    rdy_mode = v.rdy_mode;
    ack_dly  = v.ack_dly < 0 ? int'($urandom_range(1, 6)) : v.ack_dly;
    if (v.gap != 0) begin gap_ptr = rptr + 8; gap_len_cfg = v.gap; end
    write_bytes(v.nbytes, v.rnd);
    wait_done($sformatf("v%0d_done_in_time", idx), b_done, v.exp_pkts);
    repeat (5) @(negedge clk);
    gap_len_cfg = 0;
    chk($sformatf("v%0d_pkt_done_count", idx), 64'(n_done - b_done), 64'(v.exp_pkts));
    chk($sformatf("v%0d_fifo_reads", idx), 64'(n_reads - b_reads), 64'(v.exp_reads));
    chk($sformatf("v%0d_bytes_out", idx), 64'(rx_cnt - b_rx), 64'(v.exp_pkts * PKT_LEN));
    check_data($sformatf("v%0d_byte_order", idx), b_rx, b_exp, v.exp_pkts * PKT_LEN);
    chk($sformatf("v%0d_underflow", idx), 64'(n_under - b_under), 64'd0);
    chk($sformatf("v%0d_stall_stable", idx), 64'(stall_err - b_stall), 64'd0);
    chk($sformatf("v%0d_tx_len", idx), 64'(len_at_ack), 64'(PKT_LEN));
    chk($sformatf("v%0d_fifo_left", idx), 64'(wptr - rptr), 64'(v.nbytes - v.exp_reads));
    chk($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
    if (idx == 0) begin
      chk("v0_consecutive", 64'(rx_cyc[(b_rx + 15) % 4096] - rx_cyc[b_rx % 4096]), 64'd15);
      chk("v0_ack_latency", 64'(rx_cyc[b_rx % 4096] - ack_cyc), 64'd2);
    end
    if (v.gap != 0)
      chk_range($sformatf("v%0d_valid_drop_in_gap", idx), idle_valid - b_idle, v.gap - 5, 1000);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t vecs [6];
    vec_t v_clean;
    int b_done, b_rx, b_reads, b_req, wcyc;
    bit ok;

    vecs[0] = '{16, 0,  3,  0, 0, 1, 16};   // 0x00..0x0F, ready high
    vecs[1] = '{16, 1,  3,  0, 0, 1, 16};   // ready toggling
    vecs[2] = '{16, 0,  1, 20, 1, 1, 16};   // empty gap mid-packet
    vecs[3] = '{48, 2, -1,  0, 1, 3, 48};   // random back-to-back packets
    vecs[4] = '{32, 2,  5,  0, 1, 2, 32};
    vecs[5] = '{16, 2,  1,  0, 1, 1, 16};
    v_clean = '{16, 0,  2,  0, 1, 1, 16};

    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({fifo_re, tx_req, tx_data_valid, pkt_done, busy, tx_data, tx_len}), 64'd0);
    @(posedge clk); #1 srst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // abort after five transfers
    b_done = n_done; b_rx = rx_cnt;
    rdy_mode = 0; ack_dly = 2;
    write_bytes(16, 1);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (rx_cnt - b_rx >= 5) begin ok = 1'b1; break; end
    end
    chk("abort_reached_5", 64'(ok), 64'd1);
    @(posedge clk); #1 srst = 1'b1;
    #1;
    chk("abort_outputs", 64'({fifo_re, tx_req, tx_data_valid, pkt_done, busy, tx_data, tx_len}), 64'd0);
    flush_gen++;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    chk("abort_no_pkt_done", 64'(n_done - b_done), 64'd0);
    chk("abort_bytes", 64'(rx_cnt - b_rx), 64'd5);
    run_vec(v_clean, 6);

    // short residue: flushed only when the idle timeout is built in
    b_done = n_done; b_rx = rx_cnt; b_reads = n_reads; b_req = n_req_rise;
    rdy_mode = 0; ack_dly = 2;
`ifdef PKT_TIMEOUT_EN
    write_bytes(5, 1);
    wcyc = cyc;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (n_req_rise != b_req) begin ok = 1'b1; break; end
    end
    chk("to_req_seen", 64'(ok), 64'd1);
    chk_range("to_req_delay", req_rise_cyc - wcyc, 95, 105);
    wait_done("to_done_in_time", b_done, 1);
    chk("to_tx_len", 64'(len_at_ack), 64'd5);
    chk("to_bytes_out", 64'(rx_cnt - b_rx), 64'd5);
    check_data("to_byte_order", b_rx, exp_cnt - 5, 5);
    chk("to_fifo_reads", 64'(n_reads - b_reads), 64'd5);
`else
    write_bytes(5, 1);
    wcyc = cyc;
    repeat (10000) @(negedge clk);
    chk("short_no_tx_req", 64'(n_req_rise - b_req), 64'd0);
    chk("short_no_reads", 64'(n_reads - b_reads), 64'd0);
    chk("short_fifo_left", 64'(wptr - rptr), 64'd5);
    chk("short_idle", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
